// File: rtl/bnn_param_loader_if.sv
// Byte-side and chain-side signals of the BNN parameter loader.
// master: host plus chain-tail model; slave: the loader itself.
interface bnn_param_loader_if;
  logic       start;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       byte_ready;
  logic       setup;
  logic       param_out;
  logic       param_return;
  logic       busy;
  logic       done;
  logic [7:0] rd_byte;
  logic       rd_valid;

  modport master (
    output start, byte_in, byte_valid, param_return,
    input  byte_ready, setup, param_out, busy, done, rd_byte, rd_valid
  );

  modport slave (
    input  start, byte_in, byte_valid, param_return,
    output byte_ready, setup, param_out, busy, done, rd_byte, rd_valid
  );
endinterface

// File: rtl/bnn_param_loader.sv
// Serial parameter loader for a daisy chain of BNN neurons.
// Shifts host bytes MSB-first into the chain for exactly one chain length and
// reassembles the bits falling out of the chain tail into readback bytes.
module bnn_param_loader #(
  parameter int unsigned NEURONS   = 4,
  parameter int unsigned INPUTS    = 8,
  parameter int unsigned BIAS_BITS = 3
) (
  input logic               clk,
  input logic               reset,
  bnn_param_loader_if.slave bus
);
  localparam int unsigned CHAIN_BITS = NEURONS * (INPUTS + BIAS_BITS);
  localparam int unsigned TAIL       = CHAIN_BITS % 8;
  // Left-justify shift for the partial final readback byte.
  localparam int unsigned PAD        = (8 - TAIL) % 8;
  localparam int unsigned CNT_W      = $clog2(CHAIN_BITS + 1);

  typedef enum logic [1:0] {StIdle, StWait, StShift, StDone} state_e;

  state_e           state;
  logic [CNT_W-1:0] bit_cnt;
  logic [2:0]       byte_bit;
  // Bit 7 of the current byte lives in param_out, so only the remaining 7 bits are held here.
  logic [6:0]       sreg;
  logic [6:0]       rsr;
  logic [7:0]       rsr_next;
  logic             last_bit;

  assign rsr_next = {rsr, bus.param_return};
  assign last_bit = (bit_cnt == CNT_W'(CHAIN_BITS - 1));

  // Loader FSM with registered outputs, shift datapath and tail readback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= StIdle;
      bit_cnt        <= '0;
      byte_bit       <= '0;
      sreg           <= '0;
      rsr            <= '0;
      bus.byte_ready <= 1'b0;
      bus.setup      <= 1'b0;
      bus.param_out  <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.rd_byte    <= '0;
      bus.rd_valid   <= 1'b0;
    end else begin
      bus.done     <= 1'b0;
      bus.rd_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (bus.start) begin
            state          <= StWait;
            bit_cnt        <= '0;
            bus.busy       <= 1'b1;
            bus.byte_ready <= 1'b1;
          end
        end
        StWait: begin
          // byte_ready is high for the whole of WAIT, so valid alone completes the handshake.
          if (bus.byte_valid) begin
            state          <= StShift;
            sreg           <= bus.byte_in[6:0];
            bus.param_out  <= bus.byte_in[7];
            byte_bit       <= '0;
            bus.byte_ready <= 1'b0;
            bus.setup      <= 1'b1;
          end
        end
        StShift: begin
          sreg     <= {sreg[5:0], 1'b0};
          bit_cnt  <= bit_cnt + CNT_W'(1);
          byte_bit <= byte_bit + 3'd1;
          rsr      <= rsr_next[6:0];
          if (byte_bit == 3'd7) begin
            bus.rd_byte  <= rsr_next;
            bus.rd_valid <= 1'b1;
          end else if (last_bit) begin
            bus.rd_byte  <= rsr_next << PAD;
            bus.rd_valid <= 1'b1;
          end
          if (last_bit) begin
            state         <= StDone;
            bus.setup     <= 1'b0;
            bus.param_out <= 1'b0;
            bus.done      <= 1'b1;
          end else if (byte_bit == 3'd7) begin
            state          <= StWait;
            bus.setup      <= 1'b0;
            bus.param_out  <= 1'b0;
            bus.byte_ready <= 1'b1;
          end else begin
            bus.param_out <= sreg[6];
          end
        end
        StDone: begin
          state    <= StIdle;
          bus.busy <= 1'b0;
        end
        default: state <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_bnn_param_loader.sv
// Directed bench for bnn_param_loader: a 4-neuron and a 1-neuron loader, each
// feeding a behavioural chain model whose tail drives param_return.
module tb_bnn_param_loader;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  bnn_param_loader_if u_if ();
  bnn_param_loader_if u_if1 ();

  bnn_param_loader #(.NEURONS(4), .INPUTS(8), .BIAS_BITS(3)) u_dut (
    .clk(clk), .reset(reset), .bus(u_if)
  );
  bnn_param_loader #(.NEURONS(1), .INPUTS(8), .BIAS_BITS(3)) u_dut1 (
    .clk(clk), .reset(reset), .bus(u_if1)
  );

  // Neuron chain models: head at bit 0, tail at the MSB.
  logic [43:0] chain = '0;
  logic [10:0] chain1 = '0;
  always @(posedge clk) if (u_if.setup) chain <= {chain[42:0], u_if.param_out};
  always @(posedge clk) if (u_if1.setup) chain1 <= {chain1[9:0], u_if1.param_out};
  assign u_if.param_return  = chain[43];
  assign u_if1.param_return = chain1[10];

  // Free-running activity counters; tests work on differences.
  int          n_setup = 0, n_done = 0, n_busy = 0, n_rd = 0, n_rd_done = 0;
  int          n_setup1 = 0, n_done1 = 0, n_rd1 = 0, n_rd_done1 = 0;
  logic [43:0] stream = '0;
  logic [10:0] stream1 = '0;
  logic [7:0]  rd_log [64];
  logic [7:0]  rd_log1 [16];

  always @(negedge clk) begin
    if (u_if.setup) begin
      n_setup <= n_setup + 1;
      stream  <= {stream[42:0], u_if.param_out};
    end
    if (u_if.done) n_done <= n_done + 1;
    if (u_if.busy) n_busy <= n_busy + 1;
    if (u_if.rd_valid) begin
      rd_log[n_rd[5:0]] <= u_if.rd_byte;
      n_rd <= n_rd + 1;
      if (u_if.done) n_rd_done <= n_rd_done + 1;
    end
    if (u_if1.setup) begin
      n_setup1 <= n_setup1 + 1;
      stream1  <= {stream1[9:0], u_if1.param_out};
    end
    if (u_if1.done) n_done1 <= n_done1 + 1;
    if (u_if1.rd_valid) begin
      rd_log1[n_rd1[3:0]] <= u_if1.rd_byte;
      n_rd1 <= n_rd1 + 1;
      if (u_if1.done) n_rd_done1 <= n_rd_done1 + 1;
    end
  end

  logic [7:0] load_bytes [6];
  logic [7:0] exp_rd [6];
  int s0, d0, b0, r0, rd0;

  task automatic snap();
    s0 = n_setup; d0 = n_done; b0 = n_busy; r0 = n_rd; rd0 = n_rd_done;
  endtask

  // Drives one 6-byte load on the 4-neuron loader; returns in the cycle after DONE.
  task automatic do_load(input int gap, input bit spam);
    int guard;
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      u_if.byte_in    = load_bytes[i];
      u_if.byte_valid = (gap == 0);
      guard = 0;
      while (!u_if.byte_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      total++;
      if (u_if.byte_ready !== 1'b1) begin
        bad++;
        $display("FAIL byte_ready_timeout byte=%0d got=%b want=1", i, u_if.byte_ready);
      end
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        total++;
        if (u_if.setup !== 1'b0 || u_if.byte_ready !== 1'b1) begin
          bad++;
          $display("FAIL gap_state byte=%0d setup=%b ready=%b want setup=0 ready=1", i,
                   u_if.setup, u_if.byte_ready);
        end
      end
      u_if.byte_valid = 1'b1;
      if (spam) u_if.start = 1'b1;
      @(negedge clk);
      u_if.start = 1'b0;
      if (gap > 0) u_if.byte_valid = 1'b0;
      if (spam) begin
        u_if.start = 1'b1;
        @(negedge clk);
        u_if.start = 1'b0;
      end
    end
    u_if.byte_valid = 1'b0;
    guard = 0;
    while (!u_if.done && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (u_if.done !== 1'b1) begin
      bad++;
      $display("FAIL done_timeout got=%b want=1", u_if.done);
    end
    if (spam) u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #2;
    total++;
    if ({u_if.setup, u_if.byte_ready, u_if.busy, u_if.done, u_if.param_out, u_if.rd_valid}
        !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000", {u_if.setup, u_if.byte_ready, u_if.busy,
               u_if.done, u_if.param_out, u_if.rd_valid});
    end
    total++;
    if (u_if.rd_byte !== 8'h00) begin
      bad++;
      $display("FAIL reset_rd_byte got=%h want=00", u_if.rd_byte);
    end
    total++;
    if ({u_if1.setup, u_if1.byte_ready, u_if1.busy, u_if1.done, u_if1.rd_valid} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags_n1 got=%b want=00000", {u_if1.setup, u_if1.byte_ready,
               u_if1.busy, u_if1.done, u_if1.rd_valid});
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (u_if.busy !== 1'b0 || u_if.byte_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset busy=%b ready=%b want 0 0", u_if.busy, u_if.byte_ready);
    end
  endtask

  task automatic test_basic();
    load_bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'hF0};
    snap();
    do_load(0, 1'b0);
    total++;
    if (n_setup - s0 != 44) begin bad++; $display("FAIL basic_setup got=%0d want=44", n_setup - s0); end
    total++;
    if (n_done - d0 != 1) begin bad++; $display("FAIL basic_done got=%0d want=1", n_done - d0); end
    total++;
    if (n_busy - b0 != 51) begin bad++; $display("FAIL basic_busy got=%0d want=51", n_busy - b0); end
    total++;
    if (stream !== 44'hA53CFF0081F) begin
      bad++; $display("FAIL basic_stream got=%h want=a53cff0081f", stream);
    end
    total++;
    if (chain !== 44'hA53CFF0081F) begin
      bad++; $display("FAIL basic_chain got=%h want=a53cff0081f", chain);
    end
    total++;
    if (chain[43:41] !== 3'b101 || chain[7:0] !== 8'h1F) begin
      bad++;
      $display("FAIL basic_neurons bias3=%b w0=%h want 101 1f", chain[43:41], chain[7:0]);
    end
    total++;
    if (n_rd - r0 != 6) begin bad++; $display("FAIL basic_rd_count got=%0d want=6", n_rd - r0); end
    total++;
    if (u_if.busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end got=%b want=0", u_if.busy); end
  endtask

  task automatic test_gaps();
    logic [5:0] idx;
    snap();
    do_load(3, 1'b0);
    total++;
    if (n_setup - s0 != 44) begin bad++; $display("FAIL gaps_setup got=%0d want=44", n_setup - s0); end
    total++;
    if (stream !== 44'hA53CFF0081F) begin
      bad++; $display("FAIL gaps_stream got=%h want=a53cff0081f", stream);
    end
    total++;
    if (n_busy - b0 != 69) begin bad++; $display("FAIL gaps_busy got=%0d want=69", n_busy - b0); end
    exp_rd = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'hF0};
    for (int i = 0; i < 6; i++) begin
      idx = 6'(r0 + i);
      total++;
      if (rd_log[idx] !== exp_rd[i]) begin
        bad++; $display("FAIL gaps_rd[%0d] got=%h want=%h", i, rd_log[idx], exp_rd[i]);
      end
    end
  endtask

  task automatic test_readback();
    logic [5:0] idx;
    load_bytes = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    do_load(0, 1'b0);
    load_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    snap();
    do_load(0, 1'b0);
    total++;
    if (n_rd - r0 != 6) begin bad++; $display("FAIL rb_count got=%0d want=6", n_rd - r0); end
    total++;
    if (n_rd_done - rd0 != 1) begin
      bad++; $display("FAIL rb_last_in_done got=%0d want=1", n_rd_done - rd0);
    end
    exp_rd = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00};
    for (int i = 0; i < 6; i++) begin
      idx = 6'(r0 + i);
      total++;
      if (rd_log[idx] !== exp_rd[i]) begin
        bad++; $display("FAIL rb_rd[%0d] got=%h want=%h", i, rd_log[idx], exp_rd[i]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [5:0] idx;
    load_bytes = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    snap();
    do_load(0, 1'b1);
    total++;
    if (n_busy - b0 != 51 || n_done - d0 != 1) begin
      bad++;
      $display("FAIL spam_timing busy=%0d done=%0d want 51 1", n_busy - b0, n_done - d0);
    end
    total++;
    if (stream !== 44'h123456789AB) begin
      bad++; $display("FAIL spam_stream got=%h want=123456789ab", stream);
    end
    total++;
    if (u_if.busy !== 1'b0) begin bad++; $display("FAIL spam_idle got=%b want=0", u_if.busy); end
    load_bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'hF0};
    snap();
    do_load(0, 1'b0);
    total++;
    if (n_done - d0 != 1 || chain !== 44'hA53CFF0081F) begin
      bad++;
      $display("FAIL restart done=%0d chain=%h want 1 a53cff0081f", n_done - d0, chain);
    end
    idx = 6'(r0 + 5);
    total++;
    if (rd_log[idx] !== 8'hB0) begin
      bad++; $display("FAIL restart_tail got=%h want=b0", rd_log[idx]);
    end
  endtask

  task automatic test_reset_mid();
    int guard;
    snap();
    u_if.start = 1'b1;
    @(negedge clk);
    u_if.start = 1'b0;
    u_if.byte_in = 8'h55;
    u_if.byte_valid = 1'b1;
    guard = 0;
    while (n_setup - s0 < 20 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (u_if.setup !== 1'b1) begin bad++; $display("FAIL mid_shifting got=%b want=1", u_if.setup); end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({u_if.setup, u_if.byte_ready, u_if.busy, u_if.param_out} !== 4'b0) begin
      bad++;
      $display("FAIL mid_reset_async got=%b want=0000", {u_if.setup, u_if.byte_ready, u_if.busy,
               u_if.param_out});
    end
    @(negedge clk);
    reset = 1'b0;
    u_if.byte_valid = 1'b0;
    @(negedge clk);
    load_bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'hF0};
    snap();
    do_load(0, 1'b0);
    total++;
    if (n_setup - s0 != 44 || n_done - d0 != 1 || chain !== 44'hA53CFF0081F) begin
      bad++;
      $display("FAIL mid_reload setup=%0d done=%0d chain=%h want 44 1 a53cff0081f",
               n_setup - s0, n_done - d0, chain);
    end
  endtask

  task automatic load1();
    int guard;
    u_if1.start = 1'b1;
    @(negedge clk);
    u_if1.start = 1'b0;
    u_if1.byte_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      u_if1.byte_in = (i == 0) ? 8'hC3 : 8'hE0;
      guard = 0;
      while (!u_if1.byte_ready && guard < 100) begin
        @(negedge clk);
        guard++;
      end
      @(negedge clk);
    end
    u_if1.byte_valid = 1'b0;
    guard = 0;
    while (!u_if1.done && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (u_if1.done !== 1'b1) begin bad++; $display("FAIL n1_done_timeout got=0 want=1"); end
    @(negedge clk);
  endtask

  task automatic test_small_chain();
    int s, d, r, rdd;
    logic [3:0] idx;
    s = n_setup1; d = n_done1; r = n_rd1;
    load1();
    total++;
    if (n_setup1 - s != 11 || n_done1 - d != 1) begin
      bad++;
      $display("FAIL n1_counts setup=%0d done=%0d want 11 1", n_setup1 - s, n_done1 - d);
    end
    total++;
    if (stream1 !== 11'h61F || chain1 !== 11'h61F) begin
      bad++; $display("FAIL n1_stream got=%h chain=%h want=61f", stream1, chain1);
    end
    total++;
    if (n_rd1 - r != 2) begin bad++; $display("FAIL n1_rd_count got=%0d want=2", n_rd1 - r); end
    r = n_rd1; rdd = n_rd_done1;
    load1();
    idx = 4'(r);
    total++;
    if (rd_log1[idx] !== 8'hC3) begin bad++; $display("FAIL n1_rd0 got=%h want=c3", rd_log1[idx]); end
    idx = 4'(r + 1);
    total++;
    if (rd_log1[idx] !== 8'hE0) begin bad++; $display("FAIL n1_rd1 got=%h want=e0", rd_log1[idx]); end
    total++;
    if (n_rd_done1 - rdd != 1) begin
      bad++; $display("FAIL n1_tail_in_done got=%0d want=1", n_rd_done1 - rdd);
    end
  endtask

  initial begin
    u_if.start = 1'b0; u_if.byte_in = '0; u_if.byte_valid = 1'b0;
    u_if1.start = 1'b0; u_if1.byte_in = '0; u_if1.byte_valid = 1'b0;
    test_reset();
    test_basic();
    test_gaps();
    test_readback();
    test_start_ignored();
    test_reset_mid();
    test_small_chain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule
